uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

Synthesizable UART receiver: the receive-side counterpart of the device1 transmit path. It recovers asynchronous serial frames from the `rx` line using 16x oversampling. It checks parity and stop bits, and presents each received character through a single-entry valid/ready holding register. It sits in the HDL top behind the UART interface serial line and feeds the receive-side BFM and monitor logic. It also serves as a loopback checker for frames driven by the device1 agent.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: oversample ticks per bit period. Fixed at 16; the mid-bit sample point is tick 7.
- `DIV_W`, default 16: width of the baud divider input.

Ports:
- `clk`, input, 1: single clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx`, input, 1: asynchronous serial line; idle high.
- `baud_div`, input, DIV_W: clk cycles per oversample tick. A value of 0 is treated as 1.
- `data_bits`, input, 2: character length. 0 = 5 bits, 1 = 6, 2 = 7, 3 = 8.
- `parity_en`, input, 1: a parity bit follows the data bits.
- `parity_odd`, input, 1: 1 = odd parity, 0 = even.
- `stop2`, input, 1: two stop bits expected.
- `rx_data`, output, 8: received character, LSB-aligned, unused upper bits zero.
- `rx_valid`, output, 1: `rx_data` and the error flags are valid.
- `rx_ready`, input, 1: consumer accepts the character.
- `parity_err`, output, 1: parity mismatch on the held character.
- `framing_err`, output, 1: a stop bit was sampled low on the held character.
- `overrun_err`, output, 1: one-cycle pulse when a completed frame is dropped.

## Operation
- Line conditioning: `rx` passes through a 2-flop synchronizer (reset value 1), then an edge-detect register.
- Tick generator: a DIV_W-bit counter pulses `tick` for one clk cycle every max(`baud_div`,1) cycles.
  - The counter runs freely in IDLE.
  - It is cleared on start detection.
- Bit timer: a 4-bit tick counter. A sample is taken when it equals 7; it wraps from 15 to 0.
- Configuration (`data_bits`, `parity_en`, `parity_odd`, `stop2`) is latched at start detection and held for the whole frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE → START on a synchronized falling edge. The tick counter and bit timer are cleared.
  - START: at sample point 7, if the line is still 0, go to DATA. Otherwise it is a false start: return to IDLE and emit no flags.
  - DATA: shift in the sampled bit LSB-first every 16 ticks. After N bits, go to PARITY if the latched `parity_en` is set, else to STOP1.
  - PARITY: sample the parity bit. The error is the XOR of the data bits, the parity bit and `parity_odd`, and must equal 0 for a good frame. Then go to STOP1.
  - STOP1: sample; a 0 sets the framing error. Go to STOP2 if `stop2`, else complete the frame.
  - STOP2: sample; a 0 also sets the framing error. Then complete the frame.
- Frame completion at the last stop sample point:
  - If the holding register is empty, or is being consumed in this same cycle (`rx_valid && rx_ready`), load `rx_data`, `parity_err` and `framing_err`, and set `rx_valid`.
  - Otherwise pulse `overrun_err`, drop the new frame, and leave the held data and flags unchanged.
  - In all cases return to IDLE. The next falling edge is detectable from the next clk onward, i.e. from the middle of the stop bit.
- Handshake:
  - `rx_valid` stays high until a cycle with `rx_ready` = 1.
  - It clears on the following edge unless a new frame loads in that same cycle, in which case it stays high with the new data.
  - `rx_ready` while `rx_valid` = 0 has no effect.
- Break: a line held low through a stop bit is reported as a framing error with `rx_data` = 0. The receiver re-arms only after it sees a rising edge followed by a new falling edge.

## Timing
- Reset values: `rx_valid`, `parity_err`, `framing_err`, `overrun_err` = 0; `rx_data` = 0. FSM in IDLE, counters at 0, synchronizer at 1.
- Asserting `rst_n` mid-frame aborts the frame immediately, with no output pulse. After release, the receiver waits for a fresh falling edge.
- Input latency: 2 clk cycles from the `rx` pin to the synchronized value, plus 1 cycle for edge detect.
- Bit period = 16 × max(`baud_div`,1) clk cycles.
- The start sample falls 8 ticks after the detected edge. Each later sample follows the previous one by 16 ticks.
- `rx_valid` rises 1 clk after the tick of the last stop sample. `overrun_err` is high for exactly that one cycle.
- Error flags change only when a new frame is loaded; they are cleared together with `rx_valid`.

## Test plan
- 8N1, `baud_div`=4 (64 clk/bit), send 0xA5 → one `rx_valid` with `rx_data`=0xA5, `parity_err`=0, `framing_err`=0. `rx_valid` holds until `rx_ready` and clears the cycle after.
- 7E1 (`data_bits`=2, even parity), send 0x55 with parity bit 1 → `rx_data`=0x55, `parity_err`=1. Resend with parity bit 0 → `parity_err`=0.
- 5O2 (`data_bits`=0, odd parity, `stop2`), send 0x1F with parity 0 and second stop bit 0 → `rx_data`=0x1F, `framing_err`=1, `parity_err`=0.
- A low glitch of 3 ticks (12 clk at `baud_div`=4) → no `rx_valid`, and the FSM is back in IDLE. Then send 0x3C → `rx_data`=0x3C.
- With `rx_ready`=0, send 0x11 then 0x22 back to back → `rx_data`=0x11 held, and a one-cycle `overrun_err` at 0x22 completion. Then `rx_ready`=1 → `rx_valid` falls.
- Assert `rst_n` low during data bit 3 of 0xF0, release, then send 0x81 → no output for the aborted frame, then `rx_data`=0x81. The line held low for 12 bit times → `framing_err`=1 with `rx_data`=0x00, once only.

Source files
------------

// File: rtl/uart_rx_deserializer_if.sv
// Receive-side holding-register interface: character, error flags and valid/ready handshake.
interface uart_rx_deserializer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overrun_err;

  modport master (
    output rx_data, rx_valid, parity_err, framing_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, framing_err, overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 16x-oversampled UART receiver with parity/stop checking and a single-entry
// valid/ready holding register.
module uart_rx_deserializer #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  uart_rx_deserializer_if.master rx_if
);

  localparam logic [3:0] SamplePt = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop1, StStop2} state_e;

  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_last;
  logic [3:0]       bit_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [2:0]       last_idx;
  logic [7:0]       data_q;
  logic             perr_q, ferr_q;
  logic [1:0]       cfg_bits_q;
  logic             cfg_par_q, cfg_odd_q, cfg_stop2_q;
  state_e           state_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q, parity_err_q, framing_err_q, overrun_q;
  logic             fall, tick, sample, frame_done, stop_err, load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_comb begin
    fall       = rx_prev_q & ~rx_s2_q;
    div_last   = (baud_div == '0) ? '0 : baud_div - 1'b1;
    // >= rather than == so a divider lowered while idle cannot strand the counter
    tick       = (div_cnt_q >= div_last);
    sample     = tick && (bit_cnt_q == SamplePt);
    last_idx   = 3'd4 + {1'b0, cfg_bits_q};
    frame_done = sample && ((state_q == StStop1 && !cfg_stop2_q) || state_q == StStop2);
    stop_err   = ferr_q | ~rx_s2_q;
    load       = frame_done && (!rx_valid_q || rx_if.rx_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      bit_idx_q     <= '0;
      data_q        <= '0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      cfg_bits_q    <= '0;
      cfg_par_q     <= 1'b0;
      cfg_odd_q     <= 1'b0;
      cfg_stop2_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      overrun_q <= 1'b0;

      if (state_q == StIdle && fall) div_cnt_q <= '0;
      else if (tick)                 div_cnt_q <= '0;
      else                           div_cnt_q <= div_cnt_q + 1'b1;

      if (state_q == StIdle) bit_cnt_q <= '0;
      else if (tick)         bit_cnt_q <= bit_cnt_q + 4'd1;

      if (rx_valid_q && rx_if.rx_ready) begin
        rx_valid_q    <= 1'b0;
        parity_err_q  <= 1'b0;
        framing_err_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (fall) begin
            state_q     <= StStart;
            cfg_bits_q  <= data_bits;
            cfg_par_q   <= parity_en;
            cfg_odd_q   <= parity_odd;
            cfg_stop2_q <= stop2;
            data_q      <= '0;
            bit_idx_q   <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
          end
        end
        StStart: begin
          if (sample) state_q <= rx_s2_q ? StIdle : StData;
        end
        StData: begin
          if (sample) begin
            data_q[bit_idx_q] <= rx_s2_q;
            bit_idx_q         <= bit_idx_q + 3'd1;
            if (bit_idx_q == last_idx) state_q <= cfg_par_q ? StParity : StStop1;
          end
        end
        StParity: begin
          if (sample) begin
            perr_q  <= ^data_q ^ rx_s2_q ^ cfg_odd_q;
            state_q <= StStop1;
          end
        end
        StStop1: begin
          if (sample && cfg_stop2_q) begin
            ferr_q  <= ~rx_s2_q;
            state_q <= StStop2;
          end
        end
        StStop2: ;
        default: state_q <= StIdle;
      endcase

      if (frame_done) begin
        state_q <= StIdle;
        if (load) begin
          rx_data_q     <= data_q;
          parity_err_q  <= perr_q;
          framing_err_q <= stop_err;
          rx_valid_q    <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign rx_if.rx_data     = rx_data_q;
  assign rx_if.rx_valid    = rx_valid_q;
  assign rx_if.parity_err  = parity_err_q;
  assign rx_if.framing_err = framing_err_q;
  assign rx_if.overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench: frames are built from the serial-format rules, expected
// characters are queued at send time and a monitor checks each handshake.
module tb_uart_rx_deserializer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic        parity_en, parity_odd, stop2;

  uart_rx_deserializer_if bus ();

  uart_rx_deserializer #(.OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .rx_if      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_ovr  = 0;
  int   got_ovr  = 0;
  int   ovr_wide = 0;
  int   bitclk   = 64;
  logic chk_low  = 1'b0;
  logic ovr_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted character must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_low) begin
        check("valid_clears_after_accept", 32'(bus.rx_valid), 32'd0);
        chk_low = 1'b0;
      end
      if (bus.rx_valid && bus.rx_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got data %0h expected no frame", bus.rx_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rx_data", 32'(bus.rx_data), 32'(e.d));
          check("parity_err", 32'(bus.parity_err), 32'(e.pe));
          check("framing_err", 32'(bus.framing_err), 32'(e.fe));
        end
        chk_low = 1'b1;
      end
      if (bus.overrun_err) got_ovr++;
      if (bus.overrun_err && ovr_prev) ovr_wide++;
      ovr_prev = bus.overrun_err;
    end else begin
      chk_low  = 1'b0;
      ovr_prev = 1'b0;
    end
  end

  task automatic set_cfg(input int div, input int nb, input bit pen, input bit podd,
                         input bit s2);
    baud_div   = 16'(div);
    data_bits  = 2'(nb - 5);
    parity_en  = pen;
    parity_odd = podd;
    stop2      = s2;
    bitclk     = 16 * ((div == 0) ? 1 : div);
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (bitclk) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * bitclk) @(negedge clk);
  endtask

  // Sends one frame under the current configuration; pflip corrupts the parity bit.
  task automatic send(input logic [7:0] d, input bit pflip, input bit s1v, input bit s2v,
                      input bit dropped, input int gap);
    int         nb;
    logic [7:0] m;
    logic       pbit;
    nb   = int'(data_bits) + 5;
    m    = d & 8'((1 << nb) - 1);
    pbit = logic'($countones(m) % 2) ^ parity_odd;
    if (dropped) exp_ovr++;
    else q.push_back('{d: m, pe: parity_en & pflip, fe: !s1v || (stop2 && !s2v)});
    bit_out(1'b0);
    for (int i = 0; i < nb; i++) bit_out(m[i]);
    if (parity_en) bit_out(pbit ^ pflip);
    bit_out(s1v);
    if (stop2) bit_out(s2v);
    idle_bits(gap);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 bus.rx_ready = r;
  endtask

  initial begin
    rx           = 1'b1;
    rst_n        = 1'b0;
    bus.rx_ready = 1'b0;
    set_cfg(4, 8, 0, 0, 0);
    repeat (5) @(negedge clk);
    check("reset_valid", 32'(bus.rx_valid), 32'd0);
    check("reset_data", 32'(bus.rx_data), 32'd0);
    check("reset_perr", 32'(bus.parity_err), 32'd0);
    check("reset_ferr", 32'(bus.framing_err), 32'd0);
    check("reset_ovr", 32'(bus.overrun_err), 32'd0);
    rst_n = 1'b1;
    idle_bits(1);

    // 8N1 0xA5, held until ready
    send(8'hA5, 0, 1, 1, 0, 1);
    check("hold_valid", 32'(bus.rx_valid), 32'd1);
    check("hold_data", 32'(bus.rx_data), 32'hA5);
    repeat (50) @(negedge clk);
    check("hold_valid_later", 32'(bus.rx_valid), 32'd1);
    set_ready(1'b1);
    idle_bits(1);

    // 7E1 bad then good parity
    set_cfg(4, 7, 1, 0, 0);
    send(8'h55, 1, 1, 1, 0, 1);
    send(8'h55, 0, 1, 1, 0, 1);

    // 5O2 with low second stop bit
    set_cfg(4, 5, 1, 1, 1);
    send(8'h1F, 0, 1, 0, 0, 2);

    // False start glitch, then a real frame
    set_cfg(4, 8, 0, 0, 0);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    idle_bits(2);
    send(8'h3C, 0, 1, 1, 0, 1);

    // Overrun: second frame dropped while first is held
    set_ready(1'b0);
    send(8'h11, 0, 1, 1, 0, 0);
    send(8'h22, 0, 1, 1, 1, 1);
    check("overrun_held_data", 32'(bus.rx_data), 32'h11);
    check("overrun_held_valid", 32'(bus.rx_valid), 32'd1);
    set_ready(1'b1);
    idle_bits(1);

    // Reset during data bit 3 of 0xF0
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'b0);
    repeat (bitclk / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("midframe_reset_valid", 32'(bus.rx_valid), 32'd0);
    rst_n = 1'b1;
    idle_bits(2);
    send(8'h81, 0, 1, 1, 0, 1);

    // Break: 12 bit times low
    q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    rx = 1'b0;
    repeat (12 * bitclk) @(negedge clk);
    idle_bits(2);

    // Randomized frames and configurations
    for (int n = 0; n < 20; n++) begin
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(5, 8)), bit'($urandom % 2),
              bit'($urandom % 2), bit'($urandom % 2));
      send(8'($urandom), ($urandom % 4) == 0, ($urandom % 5) != 0, ($urandom % 5) != 0, 0,
           int'($urandom_range(1, 2)));
    end

    repeat (200) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("overrun_count", 32'(got_ovr), 32'(exp_ovr));
    check("overrun_single_cycle", 32'(ovr_wide), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
